// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect controls in, fetch address and RAS status out
interface pc_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 16
);
   logic              stall;
   logic              branch_taken;
   logic [OFF_W-1:0]  branch_off;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic              call;
   logic              ret;
   logic              exc;
   logic              eret;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus;
   logic [ADDR_W-1:0] epc;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_err;

   modport master (
      output stall, branch_taken, branch_off, jump, jump_target, call, ret, exc, eret,
      input  pc, pc_plus, epc, ras_empty, ras_full, ras_err
   );

   modport slave (
      input  stall, branch_taken, branch_off, jump, jump_target, call, ret, exc, eret,
      output pc, pc_plus, epc, ras_empty, ras_full, ras_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with stall, branch/jump, circular RAS and EPC
module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter int                INC       = 4,
   parameter int                OFF_W     = 16,
   parameter int                RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h80)
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   localparam int SH    = $clog2(INC);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
   logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];

   logic [ADDR_W-1:0]       pc_plus;
   logic signed [OFF_W-1:0] off_s;
   logic [ADDR_W-1:0]       off_ext;
   logic [ADDR_W-1:0]       br_target;
   logic [ADDR_W-1:0]       ras_top;

   assign pc_plus   = pc_q + ADDR_W'(INC);
   assign off_s     = bus.branch_off;
   assign off_ext   = ADDR_W'(off_s);
   assign br_target = pc_plus + (off_ext << SH);
   // ptr_q names the next free slot, so the top of stack sits one below it
   assign ras_top   = ras_mem_q[ptr_q - PTR_W'(1)];

   always_comb begin
      pc_d      = pc_q;
      epc_d     = epc_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ras_mem_d = ras_mem_q;
      if (bus.exc) begin
         pc_d  = EXC_VEC;
         epc_d = pc_q;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.eret) begin
         pc_d = epc_q;
      end else if (bus.ret) begin
         if (cnt_q != '0) begin
            pc_d  = ras_top;
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            pc_d  = pc_plus;
            err_d = 1'b1;
         end
      end else if (bus.jump) begin
         pc_d = bus.jump_target & ALIGN_MASK;
         if (bus.call) begin
            // a full stack wraps onto its oldest entry; depth saturates
            ras_mem_d[ptr_q] = pc_plus;
            ptr_d            = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else if (bus.branch_taken) begin
         pc_d = br_target;
      end else begin
         pc_d = pc_plus;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         epc_q <= '0;
         ptr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      ras_mem_q <= ras_mem_d;
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus   = pc_plus;
   assign bus.epc       = epc_q;
   assign bus.ras_empty = (cnt_q == '0);
   assign bus.ras_full  = (cnt_q == CNT_MAX);
   assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(32), .OFF_W(16)) bus ();

   pc_sequencer #(
      .ADDR_W(32), .INC(4), .OFF_W(16), .RAS_DEPTH(4),
      .RESET_VEC(32'h0), .EXC_VEC(32'h80)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        empty;
      logic        full;
      logic        err;
   } exp_t;

   exp_t  exp_q [$];
   string tag_q [$];
   int    checks   = 0;
   int    failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic drive(input bit rst, input bit st, input bit br, input logic [15:0] off,
                        input bit jmp, input logic [31:0] tgt, input bit cl, input bit rt,
                        input bit ex, input bit er);
      reset            = rst;
      bus.stall        = st;
      bus.branch_taken = br;
      bus.branch_off   = off;
      bus.jump         = jmp;
      bus.jump_target  = tgt;
      bus.call         = cl;
      bus.ret          = rt;
      bus.exc          = ex;
      bus.eret         = er;
   endtask

   task automatic idle();
      drive(0, 0, 0, 16'h0, 0, 32'h0, 0, 0, 0, 0);
   endtask

   task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                       input bit empty, input bit full, input bit err);
      exp_t e;
      exp_t got;
      string t;
      e.pc = pc; e.epc = epc; e.empty = empty; e.full = full; e.err = err;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         t   = tag_q.pop_front();
         check({t, "_pc"},    bus.pc,               got.pc);
         check({t, "_epc"},   bus.epc,              got.epc);
         check({t, "_empty"}, {31'd0, bus.ras_empty}, {31'd0, got.empty});
         check({t, "_full"},  {31'd0, bus.ras_full},  {31'd0, got.full});
         check({t, "_err"},   {31'd0, bus.ras_err},   {31'd0, got.err});
      end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step("rst", 32'h0, 32'h0, 1, 0, 0);
      idle();
      step("seq4", 32'h4, 32'h0, 1, 0, 0);
      step("seq8", 32'h8, 32'h0, 1, 0, 0);
      step("seqc", 32'hC, 32'h0, 1, 0, 0);
      check("pc_plus_c", bus.pc_plus, 32'h10);
      drive(0, 1, 0, 16'h0, 0, 32'h0, 0, 0, 0, 0);
      step("stall0", 32'hC, 32'h0, 1, 0, 0);
      drive(0, 1, 1, 16'h7, 1, 32'h500, 1, 0, 0, 0);
      step("stall1", 32'hC, 32'h0, 1, 0, 0);
      idle();
      step("seq10", 32'h10, 32'h0, 1, 0, 0);
      drive(0, 0, 1, 16'hFFFE, 0, 32'h0, 0, 0, 0, 0);
      step("br_neg", 32'hC, 32'h0, 1, 0, 0);
      drive(0, 0, 0, 16'h0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      step("jmp_top", 32'hFFFF_FFFC, 32'h0, 1, 0, 0);
      check("pc_plus_wrap", bus.pc_plus, 32'h0);
      idle();
      step("wrap", 32'h0, 32'h0, 1, 0, 0);
      drive(0, 0, 0, 16'h0, 1, 32'h20, 0, 0, 0, 0);
      step("jmp20", 32'h20, 32'h0, 1, 0, 0);
      drive(0, 0, 0, 16'h0, 1, 32'h103, 1, 0, 0, 0);
      step("call", 32'h100, 32'h0, 0, 0, 0);
      drive(0, 0, 0, 16'h0, 0, 32'h0, 0, 1, 0, 0);
      step("ret", 32'h24, 32'h0, 1, 0, 0);
      step("ret_empty", 32'h28, 32'h0, 1, 0, 1);
      drive(0, 0, 0, 16'h0, 1, 32'h300, 1, 1, 0, 0);
      step("ret_jmp", 32'h2C, 32'h0, 1, 0, 1);

      drive(1, 0, 0, 16'h0, 0, 32'h0, 0, 0, 0, 0);
      step("rst2", 32'h0, 32'h0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 16'h0, 1, 32'(i + 1) * 32'h100, 1, 0, 0, 0);
         step($sformatf("nest%0d", i), 32'(i + 1) * 32'h100, 32'h0, 0, (i >= 3), 0);
      end
      drive(0, 0, 0, 16'h0, 0, 32'h0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("unwind%0d", i), 32'h404 - 32'(i) * 32'h100, 32'h0, (i == 3), 0, 0);
      end
      step("unwind_err", 32'h108, 32'h0, 1, 0, 1);

      drive(0, 0, 0, 16'h0, 1, 32'h40, 0, 0, 0, 0);
      step("jmp40", 32'h40, 32'h0, 1, 0, 1);
      drive(0, 1, 0, 16'h0, 1, 32'h200, 0, 0, 1, 0);
      step("exc", 32'h80, 32'h40, 1, 0, 1);
      drive(0, 0, 0, 16'h0, 0, 32'h0, 0, 0, 0, 1);
      step("eret", 32'h40, 32'h40, 1, 0, 1);
      drive(1, 0, 0, 16'h0, 0, 32'h0, 0, 0, 0, 1);
      step("rst_eret", 32'h0, 32'h0, 1, 0, 0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the single-cycle MIPS datapath. It holds the fetch address and selects the next PC from sequential, branch, jump, call/return and exception sources. It adds stall hold, a circular return-address stack (RAS) and an exception PC (EPC) register. It feeds the instruction memory address and receives redirect controls from the control unit and ALU.

Parameters:
ADDR_W, 32, PC/address width in bits
INC, 4, bytes per instruction; power of two, at least 1
OFF_W, 16, branch offset width (signed, in instructions)
RAS_DEPTH, 4, return-address stack entries; power of two, at least 2
RESET_VEC, 0, PC value after reset
EXC_VEC, 'h80, PC value loaded on exception

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
stall  in  1  hold PC and all state this cycle
branch_taken  in  1  take branch this cycle
branch_off  in  OFF_W  signed instruction offset, relative to pc_plus
jump  in  1  absolute jump to jump_target
jump_target  in  ADDR_W  jump destination
call  in  1  qualifier on jump: push pc_plus onto RAS; ignored unless jump=1
ret  in  1  pop RAS and go to the popped address
exc  in  1  exception: go to EXC_VEC and save pc into epc
eret  in  1  return from exception to epc
pc  out  ADDR_W  current fetch address (registered)
pc_plus  out  ADDR_W  pc+INC (combinational)
epc  out  ADDR_W  saved exception PC (registered)
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_err  out  1  sticky flag: pop from empty RAS

Behaviour:
- Reset (sync, highest priority; also mid-stall or mid-redirect): pc=RESET_VEC, epc=0, RAS count=0, RAS pointer=0, ras_err=0. Stack contents are don't-care.
- Priority when not in reset: exc > stall > eret > ret > jump > branch_taken > sequential.
- exc: pc<=EXC_VEC; epc<=pc. Applies even when stall=1. RAS is untouched.
- stall=1 with exc=0: pc, epc, RAS and ras_err all hold; every other input is ignored.
- eret: pc<=epc.
- ret with RAS non-empty: pc<=top entry; count decrements.
- ret with RAS empty: ras_err<=1; pc<=pc_plus; count stays 0.
- jump: pc<=jump_target with the low log2(INC) bits forced to 0.
- jump with call=1: also pushes pc_plus.
- ret has priority over jump, so with both asserted no push occurs.
- branch_taken: pc<=pc_plus + (sign_extend(branch_off) << log2(INC)).
- Sequential: pc<=pc_plus.
- All arithmetic is modulo 2^ADDR_W, so wrap-around at the top of the address space is silent.
- RAS is circular. A push when full overwrites the oldest entry; count stays at RAS_DEPTH and ras_err is not set.
- Each redirect takes effect at the next clk edge. Latency is 1 cycle, and there are no bubbles inside this block.
- ras_err clears only on reset.

Test Plan:
1. Test parameters: ADDR_W=32, INC=4, RESET_VEC=0, EXC_VEC=0x80, RAS_DEPTH=4.
2. Reset, then 3 idle cycles -> pc=0,4,8,0xC. Pulse stall for 2 cycles -> pc holds 0xC, then 0x10.
3. Branch: at pc=0x10, branch_taken=1 with branch_off=-2 -> pc=0xC. At pc=0xFFFFFFFC with no redirect -> pc=0 (wrap).
4. Call/return: at pc=0x20, jump+call to 0x103 -> pc=0x100, RAS top=0x24. Then ret -> pc=0x24 and ras_empty=1. A second ret -> ras_err=1 and pc=0x28.
5. RAS overflow: 5 nested calls from pc=0x0,0x100,0x200,0x300,0x400 (jump targets 0x100..0x500) -> ras_full=1. Four rets return 0x404, 0x304, 0x204, 0x104; a fifth ret sets ras_err.
6. Exception: at pc=0x40 assert exc together with stall=1 and jump=1 -> pc=0x80, epc=0x40. Then eret -> pc=0x40. Reset asserted during eret -> pc=0, epc=0.
